regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 The block SHALL have one clock, clk, and a synchronous, active-high reset, rst.
REQ-002 Parameter DATA_W, default 32, SHALL set the write data width.
REQ-003 Parameter ADDR_W, default 4, SHALL set the register address width; NREG = 2^ADDR_W.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 a_valid  input  1  requester A (ALU writeback) has a write pending.
REQ-007 a_addr  input  ADDR_W  requester A target register.
REQ-008 a_data  input  DATA_W  requester A write data.
REQ-009 a_ready  output  1  requester A granted this cycle (combinational).
REQ-010 b_valid, b_addr, b_data, b_ready SHALL mirror REQ-006..009 for requester B (load writeback).
REQ-011 rsv_valid  input  1  issue stage reserves a destination register.
REQ-012 rsv_addr  input  ADDR_W  register being reserved.
REQ-013 w_addr  output  ADDR_W  registered write address to register file.
REQ-014 w_data  output  DATA_W  registered write data to register file.
REQ-015 write_reg  output  1  registered write strobe to register file.
REQ-016 busy  output  NREG  per-register pending-write scoreboard.
REQ-017 last_grant  output  1  0 = A granted most recently, 1 = B.

Function
REQ-018 A transfer SHALL occur on a requester when valid and ready are both high at a rising clk edge.
REQ-019 ready SHALL be asserted for at most one requester per cycle and never without its valid.
REQ-020 Only one valid: that requester SHALL be granted in the same cycle.
REQ-021 Both valid: the requester not equal to last_grant SHALL be granted (round robin).
REQ-022 last_grant SHALL update to the granted requester on every transfer and hold otherwise.
REQ-023 Requesters SHALL hold valid, addr, data stable until transfer; the block SHALL NOT buffer ungranted requests.
REQ-024 On a transfer at edge N, write_reg SHALL be 1 and w_addr/w_data SHALL carry the granted addr/data for cycle N+1 (latency 1).
REQ-025 write_reg SHALL be 0 in any cycle following an edge without transfer; w_addr/w_data SHALL hold their last values.
REQ-026 Back-to-back transfers SHALL produce write_reg high on consecutive cycles, one write per cycle, no bubbles.
REQ-027 rsv_valid at an edge SHALL set busy[rsv_addr].
REQ-028 A transfer to address X at an edge SHALL clear busy[X].
REQ-029 Simultaneous reservation and transfer to the same X SHALL leave busy[X] set (new reservation wins).
REQ-030 Simultaneous reservation and transfer to different addresses SHALL apply both.
REQ-031 A transfer to an address whose busy bit is clear SHALL still be written; busy SHALL remain clear.
REQ-032 Both requesters targeting the same address SHALL be serialized per REQ-021, each producing its own write.
REQ-033 Address NREG-1 (PC) SHALL be treated identically to other addresses; PC writes are outside this block.

Reset
REQ-034 During rst at an edge: write_reg=0, w_addr=0, w_data=0, busy=0, last_grant=1 (A wins first contention).
REQ-035 While rst is high, a_ready and b_ready SHALL be 0 and no reservation SHALL be recorded.
REQ-036 Reset asserted mid-sequence SHALL drop all in-flight grants; the cycle after reset release SHALL show write_reg=0.

Verification
REQ-037 Reset release, both valid (A addr 3 data 0x11, B addr 5 data 0x22) held -> A granted first; write_reg high two consecutive cycles: (3,0x11) then (5,0x22).
REQ-038 Only B valid for 3 cycles, addr 7 data 0xA5A5A5A5 -> b_ready high each cycle, three writes to 7, last_grant=1, a_ready=0.
REQ-039 rsv_valid addr 4 at cycle 0, A writes addr 4 at cycle 2 -> busy[4]=1 after cycle 0, 0 after cycle 2 edge.
REQ-040 rsv_valid addr 9 and A transfer addr 9 in same cycle, busy[9] previously 1 -> busy[9] stays 1, write_reg next cycle with w_addr=9.
REQ-041 Both valid continuously for 6 cycles -> grants alternate A,B,A,B,A,B; no requester granted twice in a row.
REQ-042 rst pulsed for one cycle during active transfers with busy=0x00F0 -> busy=0, write_reg=0, w_addr=0, w_data=0 next cycle, first contention grants A.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: round-robin grant between the ALU (A) and
// load (B) writeback paths, one registered write per cycle, plus a
// per-register pending-write scoreboard fed by issue-stage reservations.
module regfile_write_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 4,
    localparam int unsigned NREG  = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    input  logic              rsv_valid,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic [ADDR_W-1:0] w_addr,
    output logic [DATA_W-1:0] w_data,
    output logic              write_reg,
    output logic [NREG-1:0]   busy,
    output logic              last_grant
);

    logic              grant_a;
    logic              grant_b;
    logic              xfer;
    logic [ADDR_W-1:0] xfer_addr;
    logic [DATA_W-1:0] xfer_data;

    logic              write_reg_q, write_reg_d;
    logic [ADDR_W-1:0] w_addr_q,    w_addr_d;
    logic [DATA_W-1:0] w_data_q,    w_data_d;
    logic [NREG-1:0]   busy_q,      busy_d;
    logic              last_grant_q, last_grant_d;

    // Grant selection: a lone requester wins; on contention the one not granted last wins.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!rst) begin
            if (a_valid && (!b_valid || last_grant_q)) begin
                grant_a = 1'b1;
            end else if (b_valid) begin
                grant_b = 1'b1;
            end
        end
    end

    assign xfer      = grant_a | grant_b;
    assign xfer_addr = grant_b ? b_addr : a_addr;
    assign xfer_data = grant_b ? b_data : a_data;

    // Next-state: write port, round-robin pointer and scoreboard (reservation beats clear).
    always_comb begin
        write_reg_d  = 1'b0;
        w_addr_d     = w_addr_q;
        w_data_d     = w_data_q;
        busy_d       = busy_q;
        last_grant_d = last_grant_q;
        if (xfer) begin
            write_reg_d       = 1'b1;
            w_addr_d          = xfer_addr;
            w_data_d          = xfer_data;
            last_grant_d      = grant_b;
            busy_d[xfer_addr] = 1'b0;
        end
        if (rsv_valid) begin
            busy_d[rsv_addr] = 1'b1;
        end
    end

    // State registers; reset leaves B as last winner so A takes the first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            write_reg_q  <= 1'b0;
            w_addr_q     <= '0;
            w_data_q     <= '0;
            busy_q       <= '0;
            last_grant_q <= 1'b1;
        end else begin
            write_reg_q  <= write_reg_d;
            w_addr_q     <= w_addr_d;
            w_data_q     <= w_data_d;
            busy_q       <= busy_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign a_ready    = grant_a;
    assign b_ready    = grant_b;
    assign write_reg  = write_reg_q;
    assign w_addr     = w_addr_q;
    assign w_data     = w_data_q;
    assign busy       = busy_q;
    assign last_grant = last_grant_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: directed stimulus pushes the
// expected register-file writes, a negedge monitor pops and compares them.
module tb_regfile_write_arbiter;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned NREG   = 1 << ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              a_valid, b_valid, rsv_valid;
    logic [ADDR_W-1:0] a_addr, b_addr, rsv_addr;
    logic [DATA_W-1:0] a_data, b_data;
    logic              a_ready, b_ready, write_reg, last_grant;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic [NREG-1:0]   busy;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    regfile_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
        .w_addr(w_addr), .w_data(w_data), .write_reg(write_reg),
        .busy(busy), .last_grant(last_grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Check combinational grants for the current cycle and queue the resulting write.
    task automatic grant(input string name, input logic ea, input logic eb,
                         input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        wr_t w;
        #1;
        chk({name, " a_ready"}, 64'(a_ready), 64'(ea));
        chk({name, " b_ready"}, 64'(b_ready), 64'(eb));
        if (ea || eb) begin
            w.addr = addr;
            w.data = data;
            exp_q.push_back(w);
        end
    endtask

    // Monitor: every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (write_reg === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected none", w_addr, w_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("write_addr", 64'(w_addr), 64'(e.addr));
                chk("write_data", 64'(w_data), 64'(e.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        a_valid = 1'b1; a_addr = 4'd1; a_data = 32'h1;
        b_valid = 1'b1; b_addr = 4'd2; b_data = 32'h2;
        rsv_valid = 1'b1; rsv_addr = 4'd2;
        cyc(); cyc();
        // Reset: no grants, no reservation recorded, outputs cleared
        #1;
        chk("rst a_ready", 64'(a_ready), 64'd0);
        chk("rst b_ready", 64'(b_ready), 64'd0);
        chk("rst write_reg", 64'(write_reg), 64'd0);
        chk("rst w_addr", 64'(w_addr), 64'd0);
        chk("rst w_data", 64'(w_data), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst last_grant", 64'(last_grant), 64'd1);
        a_valid = 1'b0; b_valid = 1'b0; rsv_valid = 1'b0;
        cyc();
        rst = 1'b0;

        // Contention after reset: A first, then B, back to back
        a_valid = 1'b1; a_addr = 4'd3; a_data = 32'h11;
        b_valid = 1'b1; b_addr = 4'd5; b_data = 32'h22;
        grant("c1", 1'b1, 1'b0, 4'd3, 32'h11);
        cyc();
        a_valid = 1'b0;
        chk("c1 last_grant", 64'(last_grant), 64'd0);
        chk("c1 write_reg", 64'(write_reg), 64'd1);
        grant("c2", 1'b0, 1'b1, 4'd5, 32'h22);
        cyc();
        b_valid = 1'b0;
        chk("c2 last_grant", 64'(last_grant), 64'd1);
        chk("c2 write_reg", 64'(write_reg), 64'd1);
        cyc();
        chk("idle write_reg", 64'(write_reg), 64'd0);
        chk("idle w_addr hold", 64'(w_addr), 64'd5);
        chk("idle w_data hold", 64'(w_data), 64'h22);

        // B alone for three cycles
        b_valid = 1'b1; b_addr = 4'd7; b_data = 32'hA5A5A5A5;
        for (int i = 0; i < 3; i++) begin
            grant("b_only", 1'b0, 1'b1, 4'd7, 32'hA5A5A5A5);
            cyc();
        end
        b_valid = 1'b0;
        chk("b_only last_grant", 64'(last_grant), 64'd1);

        // Reserve 4, clear it with an A write two cycles later
        rsv_valid = 1'b1; rsv_addr = 4'd4;
        cyc();
        rsv_valid = 1'b0;
        chk("rsv4 set", 64'(busy), 64'h0010);
        cyc();
        a_valid = 1'b1; a_addr = 4'd4; a_data = 32'h44;
        grant("w4", 1'b1, 1'b0, 4'd4, 32'h44);
        cyc();
        a_valid = 1'b0;
        chk("rsv4 cleared", 64'(busy), 64'h0000);

        // Same-cycle reservation and write to 9: reservation wins
        rsv_valid = 1'b1; rsv_addr = 4'd9;
        cyc();
        chk("rsv9 set", 64'(busy), 64'h0200);
        a_valid = 1'b1; a_addr = 4'd9; a_data = 32'h99;
        grant("w9", 1'b1, 1'b0, 4'd9, 32'h99);
        cyc();
        chk("rsv9 wins", 64'(busy), 64'h0200);
        // Reservation of 6 alongside write to 9: both apply
        rsv_addr = 4'd6; a_data = 32'h909;
        grant("w9b", 1'b1, 1'b0, 4'd9, 32'h909);
        cyc();
        rsv_valid = 1'b0;
        chk("rsv6 clr9", 64'(busy), 64'h0040);
        // Write to non-busy PC register 15
        a_addr = 4'd15; a_data = 32'hFFFF0000;
        grant("w15", 1'b1, 1'b0, 4'd15, 32'hFFFF0000);
        cyc();
        a_valid = 1'b0;
        chk("w15 busy", 64'(busy), 64'h0040);

        // B alone so that A wins the next contention
        b_valid = 1'b1; b_addr = 4'd1; b_data = 32'h1;
        grant("b_pre", 1'b0, 1'b1, 4'd1, 32'h1);
        cyc();
        // Both valid six cycles to the same register: strict alternation
        a_valid = 1'b1; a_addr = 4'd10; a_data = 32'hA0;
        b_valid = 1'b1; b_addr = 4'd10; b_data = 32'hB0;
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) begin
                grant("rr_a", 1'b1, 1'b0, 4'd10, a_data);
                cyc();
                a_data = a_data + 32'h1;
            end else begin
                grant("rr_b", 1'b0, 1'b1, 4'd10, b_data);
                cyc();
                b_data = b_data + 32'h1;
            end
        end
        a_valid = 1'b0; b_valid = 1'b0;
        chk("rr last_grant", 64'(last_grant), 64'd1);

        // Build busy = 0x00F0
        rsv_valid = 1'b1;
        for (int r = 4; r < 8; r++) begin
            rsv_addr = 4'(r);
            cyc();
        end
        rsv_valid = 1'b0;
        chk("busy F0", 64'(busy), 64'h00F0);
        // Active transfer, then reset pulse with B still pending
        a_valid = 1'b1; a_addr = 4'd2; a_data = 32'h1234;
        b_valid = 1'b1; b_addr = 4'd3; b_data = 32'h5678;
        grant("pre_rst", 1'b1, 1'b0, 4'd2, 32'h1234);
        cyc();
        a_valid = 1'b0;
        rst = 1'b1;
        rsv_valid = 1'b1; rsv_addr = 4'd8;
        grant("in_rst", 1'b0, 1'b0, 4'd0, 32'h0);
        cyc();
        rst = 1'b0;
        rsv_valid = 1'b0;
        chk("post_rst busy", 64'(busy), 64'h0000);
        chk("post_rst write_reg", 64'(write_reg), 64'd0);
        chk("post_rst w_addr", 64'(w_addr), 64'd0);
        chk("post_rst w_data", 64'(w_data), 64'd0);
        chk("post_rst last_grant", 64'(last_grant), 64'd1);
        a_valid = 1'b1;
        grant("post_rst a", 1'b1, 1'b0, 4'd2, 32'h1234);
        cyc();
        a_valid = 1'b0;
        grant("post_rst b", 1'b0, 1'b1, 4'd3, 32'h5678);
        cyc();
        b_valid = 1'b0;
        cyc();
        cyc();

        chk("queue drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
